// File: rtl/dual_stream_arbiter_pkg.sv
// Shared types and constants for the dual-stream round-robin arbiter.
`timescale 1ns/1ps
package dual_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Burst counter is sized for the largest legal BURST_LEN (255).
    localparam int unsigned BURST_CNT_WIDTH = 8;

endpackage

// File: rtl/dual_stream_arbiter_stream_out_reg.sv
// One-entry registered output stage with valid/ready slot tracking.
// The slot is free when empty or when the current entry leaves this cycle.
`timescale 1ns/1ps
module stream_out_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_src,
    output logic                  slot_free,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  src_q;
    logic                  valid_q;

    assign slot_free = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;

    // Capture an accepted beat; drop valid once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            src_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= in_data;
            src_q   <= in_src;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/dual_stream_arbiter.sv
// Round-robin arbiter sharing one registered output stream between
// requesters A and B, with a bounded burst hold while the other waits.
// Optional transfer statistics: define DUAL_STREAM_ARBITER_STATS_EN.
`timescale 1ns/1ps
module dual_stream_arbiter
    import dual_stream_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
`ifdef DUAL_STREAM_ARBITER_STATS_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_a_data,
    input  logic                  in_a_valid,
    output logic                  in_a_ready,
    input  logic [DATA_WIDTH-1:0] in_b_data,
    input  logic                  in_b_valid,
    output logic                  in_b_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    output logic                  out_valid,
`ifdef DUAL_STREAM_ARBITER_STATS_EN
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  grant_cnt_a,
    output logic [CNT_WIDTH-1:0]  grant_cnt_b
`else
    input  logic                  out_ready
`endif
);

    localparam logic [BURST_CNT_WIDTH:0]   BURST_LEN_EXT = (BURST_CNT_WIDTH + 1)'(BURST_LEN);
    localparam logic [BURST_CNT_WIDTH-1:0] BURST_MAX     = BURST_CNT_WIDTH'(BURST_LEN - 1);

    arb_state_t                 state_q, state_d;
    logic                       last_grant_q, last_grant_d;
    logic [BURST_CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic [BURST_CNT_WIDTH:0]   cnt_inc;

    logic            slot_free;
    logic            xfer_a, xfer_b;
    logic            own_valid, other_valid, own_xfer, own_src;
    arb_state_t      other_state;
    logic [DATA_WIDTH-1:0] sel_data;

    assign in_a_ready = (state_q == GRANT_A) && slot_free;
    assign in_b_ready = (state_q == GRANT_B) && slot_free;
    assign xfer_a     = in_a_valid && in_a_ready;
    assign xfer_b     = in_b_valid && in_b_ready;
    assign sel_data   = xfer_b ? in_b_data : in_a_data;
    assign cnt_inc    = {1'b0, burst_cnt_q} + {{BURST_CNT_WIDTH{1'b0}}, 1'b1};

    stream_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (xfer_a || xfer_b),
        .in_data  (sel_data),
        .in_src   (xfer_b ? SRC_B : SRC_A),
        .slot_free(slot_free),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // View the current grant as "own" vs "other" so both grant states share one rule set.
    always_comb begin
        own_valid   = in_a_valid;
        other_valid = in_b_valid;
        own_xfer    = xfer_a;
        own_src     = SRC_A;
        other_state = GRANT_B;
        if (state_q == GRANT_B) begin
            own_valid   = in_b_valid;
            other_valid = in_a_valid;
            own_xfer    = xfer_b;
            own_src     = SRC_B;
            other_state = GRANT_A;
        end
    end

    // Next-state: grant selection, burst limit and early release.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (in_a_valid && in_b_valid) begin
                    state_d = (last_grant_q == SRC_B) ? GRANT_A : GRANT_B;
                end else if (in_a_valid) begin
                    state_d = GRANT_A;
                end else if (in_b_valid) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (own_xfer) begin
                    last_grant_d = own_src;
                    if (other_valid && (cnt_inc == BURST_LEN_EXT)) begin
                        state_d     = other_state;
                        burst_cnt_d = '0;
                    end else if (cnt_inc >= BURST_LEN_EXT) begin
                        // Uncontended owner keeps the grant; hold the count at its limit.
                        burst_cnt_d = BURST_MAX;
                    end else begin
                        burst_cnt_d = cnt_inc[BURST_CNT_WIDTH-1:0];
                    end
                end else if (!own_valid) begin
                    state_d     = other_valid ? other_state : IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Arbitration state registers; reset makes A the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_B;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

`ifdef DUAL_STREAM_ARBITER_STATS_EN
    logic [CNT_WIDTH-1:0] grant_cnt_a_q, grant_cnt_b_q;

    assign grant_cnt_a = grant_cnt_a_q;
    assign grant_cnt_b = grant_cnt_b_q;

    // Free-running, wrapping counts of accepted transfers per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_a_q <= '0;
            grant_cnt_b_q <= '0;
        end else begin
            if (xfer_a) grant_cnt_a_q <= grant_cnt_a_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (xfer_b) grant_cnt_b_q <= grant_cnt_b_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule
